// File: rtl/fp_round32_pipe.sv
// fp32 rounding stage: three-deep elastic valid/ready pipeline with clock enable.
// Build option: define FP_ROUND_RMM_EN for round-to-nearest-ties-away on rm=4 (otherwise rm=4 rounds as RNE).
module fp_round32_pipe #(
  parameter int PIPE_DEP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [2:0]  rm,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [26:0] sig_i,
  input  logic        under_i,
  input  logic        inexact_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        inexact_o
);

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
`ifdef FP_ROUND_RMM_EN
  localparam logic [2:0] RM_RMM = 3'd4;
`endif

  generate
    if (PIPE_DEP != 3) begin : g_depth_check
      $error("fp_round32_pipe supports PIPE_DEP=3 only");
    end
  endgenerate

  // lgrs = {L, G, R, S}; unlisted modes (including 5-7) round to nearest even.
  function automatic logic round_inc(input logic [2:0] mode, input logic sign, input logic [3:0] lgrs);
    logic grs;
    grs = |lgrs[2:0];
    case (mode)
      RM_RTZ:  round_inc = 1'b0;
      RM_RDN:  round_inc = sign & grs;
      RM_RUP:  round_inc = ~sign & grs;
`ifdef FP_ROUND_RMM_EN
      RM_RMM:  round_inc = lgrs[2];
`endif
      default: round_inc = lgrs[2] & (lgrs[3] | lgrs[1] | lgrs[0]);
    endcase
  endfunction

  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sign);
    case (mode)
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RDN:  ovf_to_inf = sign;
      RM_RUP:  ovf_to_inf = ~sign;
      default: ovf_to_inf = 1'b1;
    endcase
  endfunction

  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        s1_sign_q, s1_sign_d, s1_inc_q, s1_inc_d, s1_special_q, s1_special_d;
  logic        s1_tiny_q, s1_tiny_d, s1_inx_q, s1_inx_d, s1_oinf_q, s1_oinf_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [22:0] s1_frac_q, s1_frac_d;
  logic        s2_sign_q, s2_sign_d, s2_ovf_q, s2_ovf_d, s2_special_q, s2_special_d;
  logic        s2_tiny_q, s2_tiny_d, s2_inx_q, s2_inx_d, s2_oinf_q, s2_oinf_d;
  logic [30:0] s2_sum_q, s2_sum_d;
  logic [31:0] o_q, o_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic        load1_s, load2_s, load3_s, special_s;
  logic [30:0] sum_s;
  logic [31:0] res_o_s;
  logic        res_ovf_s, res_unf_s, res_inx_s;

  assign load3_s   = ce & (~v3_q | out_ready);
  assign load2_s   = ce & (~v2_q | load3_s);
  assign load1_s   = ce & (~v1_q | load2_s);
  assign in_ready  = load1_s;
  assign special_s = (exp_i == 8'hFF);
  // Specials never increment, so the sum's low bits still carry the NaN payload.
  assign sum_s     = {s1_exp_q, s1_frac_q} + {30'd0, s1_inc_q};

  always_comb begin
    res_o_s   = {s2_sign_q, s2_sum_q};
    res_ovf_s = 1'b0;
    res_unf_s = s2_tiny_q & s2_inx_q;
    res_inx_s = s2_inx_q;
    if (s2_special_q) begin
      res_unf_s = 1'b0;
      res_inx_s = 1'b0;
      if (s2_sum_q[22:0] != 23'd0) begin
        res_o_s = {s2_sign_q, 8'hFF, 1'b1, s2_sum_q[21:0]};
      end else begin
        res_o_s = {s2_sign_q, 8'hFF, 23'd0};
      end
    end else if (s2_ovf_q) begin
      res_ovf_s = 1'b1;
      res_unf_s = 1'b0;
      res_inx_s = 1'b1;
      if (s2_oinf_q) begin
        res_o_s = {s2_sign_q, 8'hFF, 23'd0};
      end else begin
        res_o_s = {s2_sign_q, 8'hFE, 23'h7FFFFF};
      end
    end else begin
      res_o_s = {s2_sign_q, s2_sum_q};
    end
  end

  always_comb begin
    v1_d = v1_q;  s1_sign_d = s1_sign_q;  s1_exp_d = s1_exp_q;  s1_frac_d = s1_frac_q;
    s1_inc_d = s1_inc_q;  s1_special_d = s1_special_q;  s1_tiny_d = s1_tiny_q;
    s1_inx_d = s1_inx_q;  s1_oinf_d = s1_oinf_q;
    v2_d = v2_q;  s2_sign_d = s2_sign_q;  s2_sum_d = s2_sum_q;  s2_ovf_d = s2_ovf_q;
    s2_special_d = s2_special_q;  s2_tiny_d = s2_tiny_q;  s2_inx_d = s2_inx_q;  s2_oinf_d = s2_oinf_q;
    v3_d = v3_q;  o_d = o_q;  ovf_d = ovf_q;  unf_d = unf_q;  inx_d = inx_q;

    if (load1_s) begin
      v1_d         = in_valid;
      s1_sign_d    = sign_i;
      s1_exp_d     = exp_i;
      s1_frac_d    = sig_i[25:3];
      s1_inc_d     = ~special_s & round_inc(rm, sign_i, sig_i[3:0]);
      s1_special_d = special_s;
      s1_tiny_d    = under_i | ((exp_i == 8'h00) & ~sig_i[26]);
      s1_inx_d     = (|sig_i[2:0]) | inexact_i;
      s1_oinf_d    = ovf_to_inf(rm, sign_i);
    end else begin
      v1_d = v1_q;
    end

    if (load2_s) begin
      v2_d         = v1_q;
      s2_sign_d    = s1_sign_q;
      s2_sum_d     = sum_s;
      s2_ovf_d     = ~s1_special_q & (sum_s[30:23] == 8'hFF);
      s2_special_d = s1_special_q;
      s2_tiny_d    = s1_tiny_q;
      s2_inx_d     = s1_inx_q;
      s2_oinf_d    = s1_oinf_q;
    end else begin
      v2_d = v2_q;
    end

    if (load3_s) begin
      v3_d = v2_q;
    end else begin
      v3_d = v3_q;
    end

    // Result registers only take real operations, so a drained output stays put.
    if (load3_s && v2_q) begin
      o_d   = res_o_s;
      ovf_d = res_ovf_s;
      unf_d = res_unf_s;
      inx_d = res_inx_s;
    end else begin
      o_d = o_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;  s1_sign_q <= 1'b0;  s1_exp_q <= 8'h00;  s1_frac_q <= 23'd0;
      s1_inc_q <= 1'b0;  s1_special_q <= 1'b0;  s1_tiny_q <= 1'b0;  s1_inx_q <= 1'b0;
      s1_oinf_q <= 1'b0;
      v2_q <= 1'b0;  s2_sign_q <= 1'b0;  s2_sum_q <= 31'd0;  s2_ovf_q <= 1'b0;
      s2_special_q <= 1'b0;  s2_tiny_q <= 1'b0;  s2_inx_q <= 1'b0;  s2_oinf_q <= 1'b0;
      v3_q <= 1'b0;  o_q <= 32'd0;  ovf_q <= 1'b0;  unf_q <= 1'b0;  inx_q <= 1'b0;
    end else begin
      v1_q <= v1_d;  s1_sign_q <= s1_sign_d;  s1_exp_q <= s1_exp_d;  s1_frac_q <= s1_frac_d;
      s1_inc_q <= s1_inc_d;  s1_special_q <= s1_special_d;  s1_tiny_q <= s1_tiny_d;
      s1_inx_q <= s1_inx_d;  s1_oinf_q <= s1_oinf_d;
      v2_q <= v2_d;  s2_sign_q <= s2_sign_d;  s2_sum_q <= s2_sum_d;  s2_ovf_q <= s2_ovf_d;
      s2_special_q <= s2_special_d;  s2_tiny_q <= s2_tiny_d;  s2_inx_q <= s2_inx_d;
      s2_oinf_q <= s2_oinf_d;
      v3_q <= v3_d;  o_q <= o_d;  ovf_q <= ovf_d;  unf_q <= unf_d;  inx_q <= inx_d;
    end
  end

  assign out_valid   = v3_q;
  assign o           = o_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_round32_pipe.sv
// Directed-vector bench for fp_round32_pipe: rounding results, flags, latency, backpressure, ce and reset.
module tb_fp_round32_pipe;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, out_ready, sign_i, under_i, inexact_i;
  logic [2:0]  rm;
  logic [7:0]  exp_i;
  logic [26:0] sig_i;
  logic        in_ready, out_valid, overflow_o, underflow_o, inexact_o;
  logic [31:0] o;

  int   checks = 0;
  int   failures = 0;
  int   sent, rcvd, stale;
  logic sb_on = 1'b0;

  fp_round32_pipe #(.PIPE_DEP(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rm(rm), .in_valid(in_valid), .in_ready(in_ready),
    .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .under_i(under_i), .inexact_i(inexact_i),
    .out_valid(out_valid), .out_ready(out_ready), .o(o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // One clock: sample ready/output at negedge, score stream outputs, report input acceptance.
  task automatic tick(output logic acc);
    logic rdy, xfer;
    @(negedge clk);
    rdy  = in_ready;
    xfer = out_valid & out_ready & ce;
    if (xfer && sb_on) begin
      chk("stream_o", o, 32'h40000000 | 32'(rcvd + 1));
      chk("stream_flags", {29'd0, overflow_o, underflow_o, inexact_o}, 32'd0);
      rcvd++;
    end
    @(posedge clk);
    acc = in_valid & rdy & ce;
    #1;
  endtask

  task automatic run_vec(input string tag, input logic s, input logic [7:0] e, input logic [26:0] sg,
                         input logic [2:0] m, input logic un, input logic inx,
                         input logic [31:0] want_o, input logic [2:0] want_f);
    logic acc;
    int   lat;
    ce = 1'b1; out_ready = 1'b1;
    sign_i = s; exp_i = e; sig_i = sg; rm = m; under_i = un; inexact_i = inx; in_valid = 1'b1;
    tick(acc);
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_o"}, o, want_o);
    chk({tag, "_flags"}, {29'd0, overflow_o, underflow_o, inexact_o}, {29'd0, want_f});
    @(posedge clk);
    #1;
  endtask

  task automatic stream_cycle(input logic ce_v, input logic ordy_v, input int n_ops);
    logic acc;
    ce = ce_v; out_ready = ordy_v;
    in_valid = (sent < n_ops);
    sign_i = 1'b0; exp_i = 8'h80; sig_i = {1'b1, 23'(sent + 1), 3'b000};
    rm = 3'd1; under_i = 1'b0; inexact_i = 1'b0;
    tick(acc);
    if (acc) sent++;
  endtask

  initial begin
    logic [31:0] rmm_tie;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sign_i = 1'b0;
    under_i = 1'b0; inexact_i = 1'b0; rm = 3'd0; exp_i = 8'h00; sig_i = 27'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_o", o, 32'd0);
    chk("rst_flags", {29'd0, overflow_o, underflow_o, inexact_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // flags expected as {overflow, underflow, inexact}
    run_vec("rne_tie_even", 1'b0, 8'h7F, 27'h4000004, 3'd0, 1'b0, 1'b0, 32'h3F800000, 3'b001);
    run_vec("rne_up",       1'b0, 8'h7F, 27'h400000C, 3'd0, 1'b0, 1'b0, 32'h3F800002, 3'b001);
    run_vec("rtz",          1'b0, 8'h7F, 27'h400000C, 3'd1, 1'b0, 1'b0, 32'h3F800001, 3'b001);
    run_vec("ovf_rne",      1'b0, 8'hFE, 27'h7FFFFFC, 3'd0, 1'b0, 1'b0, 32'h7F800000, 3'b101);
    run_vec("max_rtz",      1'b0, 8'hFE, 27'h7FFFFFC, 3'd1, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b001);
    run_vec("max_rup_neg",  1'b1, 8'hFE, 27'h7FFFFFC, 3'd3, 1'b0, 1'b0, 32'hFF7FFFFF, 3'b001);
    run_vec("ovf_rdn_neg",  1'b1, 8'hFE, 27'h7FFFFFC, 3'd2, 1'b0, 1'b0, 32'hFF800000, 3'b101);
    run_vec("max_rdn_pos",  1'b0, 8'hFE, 27'h7FFFFFC, 3'd2, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b001);
    run_vec("denorm_up",    1'b0, 8'h00, 27'h3FFFFFC, 3'd0, 1'b1, 1'b0, 32'h00800000, 3'b011);
    run_vec("denorm_rtz",   1'b0, 8'h00, 27'h3FFFFFC, 3'd1, 1'b1, 1'b0, 32'h007FFFFF, 3'b011);
    run_vec("tiny_exact",   1'b0, 8'h00, 27'h0000008, 3'd0, 1'b0, 1'b0, 32'h00000001, 3'b000);
    run_vec("qnan",         1'b0, 8'hFF, 27'h2000008, 3'd0, 1'b0, 1'b0, 32'h7FC00001, 3'b000);
    run_vec("neg_inf",      1'b1, 8'hFF, 27'h0000000, 3'd0, 1'b0, 1'b0, 32'hFF800000, 3'b000);
    run_vec("neg_zero",     1'b1, 8'h00, 27'h0000000, 3'd0, 1'b0, 1'b0, 32'h80000000, 3'b000);
    run_vec("rdn_neg",      1'b1, 8'h7F, 27'h4000001, 3'd2, 1'b0, 1'b0, 32'hBF800001, 3'b001);
    run_vec("rup_neg",      1'b1, 8'h7F, 27'h4000001, 3'd3, 1'b0, 1'b0, 32'hBF800000, 3'b001);
    run_vec("inexact_in",   1'b0, 8'h7F, 27'h4000000, 3'd1, 1'b0, 1'b1, 32'h3F800000, 3'b001);
    run_vec("rm7_as_rne",   1'b0, 8'h7F, 27'h400000C, 3'd7, 1'b0, 1'b0, 32'h3F800002, 3'b001);
    run_vec("rm5_tie_even", 1'b0, 8'h7F, 27'h4000004, 3'd5, 1'b0, 1'b0, 32'h3F800000, 3'b001);
`ifdef FP_ROUND_RMM_EN
    rmm_tie = 32'h3F800001;
`else
    rmm_tie = 32'h3F800000;
`endif
    run_vec("rm4_tie",      1'b0, 8'h7F, 27'h4000004, 3'd4, 1'b0, 1'b0, rmm_tie, 3'b001);

    // backpressure: six back-to-back ops against a stalled sink
    sent = 0; rcvd = 0; sb_on = 1'b1;
    repeat (5) stream_cycle(1'b1, 1'b0, 6);
    chk("bp_accepted", 32'(sent), 32'd3);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 40 && rcvd < 6; i++) stream_cycle(1'b1, 1'b1, 6);
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_rcvd", 32'(rcvd), 32'd6);

    // clock-enable pulse mid-stream
    sent = 0; rcvd = 0;
    repeat (3) stream_cycle(1'b1, 1'b1, 8);
    repeat (2) begin
      stream_cycle(1'b0, 1'b1, 8);
      chk("ce_in_ready", {31'd0, in_ready}, 32'd0);
    end
    for (int i = 0; i < 40 && rcvd < 8; i++) stream_cycle(1'b1, 1'b1, 8);
    chk("ce_rcvd", 32'(rcvd), 32'd8);

    // reset with three in flight
    sent = 0; rcvd = 0;
    repeat (3) stream_cycle(1'b1, 1'b0, 3);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    sb_on = 1'b0; out_ready = 1'b1; stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_stale", 32'(stale), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
